// File: rtl/dk_hs_ram_arbiter.sv
// rtl/dk_hs_ram_arbiter.sv - work RAM port arbiter between the main CPU and the hiscore engine
module dk_hs_ram_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int SETTLE = 4,
    parameter int HOLD   = 2
) (
    input  logic          I_CLK_24576M,
    input  logic          I_RESETn,
    input  logic [AW-1:0] I_CPU_A,
    input  logic [DW-1:0] I_CPU_D,
    input  logic          I_CPU_WE,
    input  logic          I_CPU_PAUSED,
    input  logic [AW-1:0] I_HS_A,
    input  logic [DW-1:0] I_HS_D,
    input  logic          I_HS_WE,
    input  logic          I_HS_REQ,
    input  logic [DW-1:0] I_RAM_Q,
    output logic [AW-1:0] O_RAM_A,
    output logic [DW-1:0] O_RAM_D,
    output logic          O_RAM_WE,
    output logic [DW-1:0] O_HS_Q,
    output logic          O_PAUSE_REQ,
    output logic          O_HS_GRANT,
    output logic          O_CONFLICT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [3:0] hold_cnt;
    logic       violation;

    // The engine may only keep the RAM while the CPU stays halted and silent.
    assign violation = (state == OWN) && (!I_CPU_PAUSED || I_CPU_WE);

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        O_RAM_A    = I_CPU_A;
        O_RAM_D    = I_CPU_D;
        O_RAM_WE   = 1'b0;
        case (state)
            IDLE: begin
                O_RAM_WE = I_CPU_WE;
                if (I_HS_REQ) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                O_RAM_WE = I_CPU_WE;
                if (!I_HS_REQ) begin
                    state_next = REL;
                end else if (settle_cnt == SETTLE_C) begin
                    state_next = OWN;
                end
            end
            OWN: begin
                O_RAM_A  = I_HS_A;
                O_RAM_D  = I_HS_D;
                O_RAM_WE = I_HS_WE && I_CPU_PAUSED;
                if (!I_HS_REQ || !I_CPU_PAUSED) begin
                    state_next = REL;
                end
            end
            REL: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset must never let a stray CPU write strobe through to the RAM.
        if (!I_RESETn) begin
            O_RAM_WE = 1'b0;
        end
    end

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            settle_cnt <= 4'd0;
            hold_cnt   <= 4'd0;
        end else if (state_next != state) begin
            settle_cnt <= 4'd0;
            hold_cnt   <= 4'd0;
        end else begin
            if (state == WAIT) begin
                if (!I_CPU_PAUSED) begin
                    settle_cnt <= 4'd0;
                end else if (settle_cnt != 4'hF) begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
            end
            if (state == REL && hold_cnt != 4'hF) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    // Status outputs are flopped from the next state so they line up with it.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_PAUSE_REQ <= 1'b0;
            O_HS_GRANT  <= 1'b0;
            O_CONFLICT  <= 1'b0;
            O_HS_Q      <= '0;
        end else begin
            O_PAUSE_REQ <= (state_next != IDLE);
            O_HS_GRANT  <= (state_next == OWN);
            O_CONFLICT  <= O_CONFLICT || violation;
            if (state == OWN) begin
                O_HS_Q <= I_RAM_Q;
            end
        end
    end

endmodule

// File: tb/tb_dk_hs_ram_arbiter.sv
// tb/tb_dk_hs_ram_arbiter.sv - randomized self-checking bench for dk_hs_ram_arbiter
module tb_dk_hs_ram_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int SETTLE = 4;
    localparam int HOLD   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cpu_a, hs_a, ram_a;
    logic [DW-1:0] cpu_d, hs_d, ram_q, ram_d, hs_q;
    logic          cpu_we, cpu_paused, hs_we, hs_req;
    logic          ram_we, pause_req, hs_grant, conflict;

    int n_checks = 0;
    int n_errors = 0;

    // Reference view: where the arbiter is in the handshake, in plain counts.
    bit            m_waiting;
    bit            m_owning;
    bit            m_conf;
    int            m_run;
    int            m_rel_left;
    logic [DW-1:0] m_hsq;

    logic          g_seen, pr_seen, we_seen, conf_seen;
    logic [AW-1:0] a_seen;
    logic [DW-1:0] d_seen, q_seen;

    always #5 clk = ~clk;

    dk_hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .HOLD(HOLD)) dut (
        .I_CLK_24576M (clk),
        .I_RESETn     (rst_n),
        .I_CPU_A      (cpu_a),
        .I_CPU_D      (cpu_d),
        .I_CPU_WE     (cpu_we),
        .I_CPU_PAUSED (cpu_paused),
        .I_HS_A       (hs_a),
        .I_HS_D       (hs_d),
        .I_HS_WE      (hs_we),
        .I_HS_REQ     (hs_req),
        .I_RAM_Q      (ram_q),
        .O_RAM_A      (ram_a),
        .O_RAM_D      (ram_d),
        .O_RAM_WE     (ram_we),
        .O_HS_Q       (hs_q),
        .O_PAUSE_REQ  (pause_req),
        .O_HS_GRANT   (hs_grant),
        .O_CONFLICT   (conflict)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting  = 1'b0;
        m_owning   = 1'b0;
        m_conf     = 1'b0;
        m_run      = 0;
        m_rel_left = 0;
        m_hsq      = '0;
    endtask

    task automatic model_step();
        if (m_owning) begin
            if (cpu_we || !cpu_paused) m_conf = 1'b1;
            m_hsq = ram_q;
            if (!hs_req || !cpu_paused) begin
                m_owning   = 1'b0;
                m_rel_left = HOLD;
            end
        end else if (m_rel_left > 0) begin
            m_rel_left--;
        end else if (m_waiting) begin
            if (!hs_req) begin
                m_waiting  = 1'b0;
                m_rel_left = HOLD;
            end else if (m_run == SETTLE) begin
                m_waiting = 1'b0;
                m_owning  = 1'b1;
            end else begin
                m_run = cpu_paused ? m_run + 1 : 0;
            end
        end else if (hs_req) begin
            m_waiting = 1'b1;
            m_run     = 0;
        end
    endtask

    task automatic compare_outputs();
        logic exp_we;
        if (!rst_n) exp_we = 1'b0;
        else if (m_owning) exp_we = hs_we && cpu_paused;
        else if (m_rel_left > 0) exp_we = 1'b0;
        else exp_we = cpu_we;
        check_val("ram_a", ram_a, m_owning ? hs_a : cpu_a);
        check_val("ram_d", ram_d, m_owning ? hs_d : cpu_d);
        check_val("ram_we", ram_we, exp_we);
        check_val("pause_req", pause_req, m_waiting || m_owning || (m_rel_left > 0));
        check_val("hs_grant", hs_grant, m_owning);
        check_val("conflict", conflict, m_conf);
        check_val("hs_q", hs_q, m_hsq);
    endtask

    // Inputs are set by the caller after a falling edge; outputs are sampled 1 ns later.
    task automatic run_cycle();
        if (!rst_n) model_reset();
        #1;
        compare_outputs();
        g_seen    = hs_grant;
        pr_seen   = pause_req;
        we_seen   = ram_we;
        conf_seen = conflict;
        a_seen    = ram_a;
        d_seen    = ram_d;
        q_seen    = hs_q;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic get_own();
        int n;
        hs_req     = 1'b1;
        cpu_paused = 1'b1;
        n = 0;
        while (!m_owning && n < 20) begin
            run_cycle();
            n++;
        end
        if (!m_owning) check_val("get_own_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_hs();
        hs_req = 1'b0;
        hs_we  = 1'b0;
        run_cycle();
        cpu_paused = 1'b0;
        for (int i = 0; i < HOLD + 2; i++) run_cycle();
    endtask

    initial begin
        int t_pr, t_grant;
        bit g_any;

        rst_n = 1'b0; cpu_a = 16'h1234; cpu_d = 8'h11; cpu_we = 1'b1; cpu_paused = 1'b0;
        hs_a = 16'h0000; hs_d = 8'h00; hs_we = 1'b0; hs_req = 1'b0; ram_q = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        run_cycle();
        check_val("reset_we_gated", we_seen, 1'b0);
        run_cycle();

        rst_n = 1'b1;
        cpu_we = 1'b0;
        run_cycle();

        // Nominal: request, paused two cycles later, hiscore write 0x5A -> 0x6100.
        hs_req = 1'b1; hs_a = 16'h6100; hs_d = 8'h5A; hs_we = 1'b1;
        t_pr = -1; t_grant = -1;
        for (int i = 0; i < 12; i++) begin
            cpu_paused = (i >= 2);
            run_cycle();
            if (pr_seen && t_pr < 0) t_pr = i;
            if (g_seen && t_grant < 0) begin
                t_grant = i;
                check_val("nom_wr_addr", a_seen, 16'h6100);
                check_val("nom_wr_data", d_seen, 8'h5A);
                check_val("nom_wr_we", we_seen, 1'b1);
            end
        end
        check_val("nom_pause_latency", t_pr, 1);
        check_val("nom_grant_latency", t_grant - 2, SETTLE + 1);
        release_hs();

        // Paused glitch: counter must restart from the final rise.
        hs_req = 1'b1; t_grant = -1;
        for (int i = 0; i < 14; i++) begin
            cpu_paused = (i >= 1 && i <= 3) || (i >= 5);
            run_cycle();
            if (g_seen && t_grant < 0) t_grant = i;
        end
        check_val("glitch_grant_latency", t_grant - 5, SETTLE + 1);
        release_hs();

        // Abandoned request: no grant, CPU writes pass again once idle.
        g_any = 1'b0; cpu_paused = 1'b0;
        for (int i = 0; i < 9; i++) begin
            hs_req = (i < 3);
            cpu_we = (i >= 6);
            cpu_a  = 16'(16'h2000 + i);
            run_cycle();
            if (g_seen) g_any = 1'b1;
            if (i == 5) check_val("abandon_rel_pause", pr_seen, 1'b1);
        end
        check_val("abandon_no_grant", g_any, 1'b0);
        check_val("abandon_cpu_we", we_seen, 1'b1);
        check_val("abandon_idle_pause", pr_seen, 1'b0);
        cpu_we = 1'b0;

        // Unpause while owning a write: write gated, sticky conflict, release.
        get_own();
        hs_we = 1'b1; hs_a = 16'h6105; cpu_paused = 1'b0;
        run_cycle();
        check_val("unpause_we_gated", we_seen, 1'b0);
        hs_req = 1'b0; hs_we = 1'b0;
        run_cycle();
        check_val("unpause_conflict", conf_seen, 1'b1);
        check_val("unpause_grant_drop", g_seen, 1'b0);
        for (int i = 0; i < 6; i++) run_cycle();
        check_val("conflict_sticky", conf_seen, 1'b1);

        // Reset in the middle of ownership.
        get_own();
        hs_we = 1'b1; hs_d = 8'hA5;
        run_cycle();
        rst_n = 1'b0;
        run_cycle();
        check_val("rst_own_grant", g_seen, 1'b0);
        check_val("rst_own_pause", pr_seen, 1'b0);
        check_val("rst_own_we", we_seen, 1'b0);
        check_val("rst_own_conflict", conf_seen, 1'b0);
        rst_n = 1'b1; hs_we = 1'b0;
        get_own();
        run_cycle();
        check_val("rst_fresh_grant", g_seen, 1'b1);

        // Read latency: data captured one clock after the RAM presents it.
        hs_a = 16'h6000; hs_we = 1'b0; ram_q = 8'hC3;
        run_cycle();
        ram_q = 8'h3C;
        run_cycle();
        check_val("read_latency", q_seen, 8'hC3);
        release_hs();
        ram_q = 8'h77;
        for (int i = 0; i < 3; i++) run_cycle();
        check_val("read_hold", q_seen, 8'h3C);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) hs_req = ~hs_req;
            if ($urandom_range(0, 4) == 0) cpu_paused = ~cpu_paused;
            cpu_a  = 16'($urandom);
            cpu_d  = 8'($urandom);
            cpu_we = ($urandom_range(0, 15) == 0);
            hs_a   = 16'($urandom);
            hs_d   = 8'($urandom);
            hs_we  = $urandom_range(0, 1) == 1;
            ram_q  = 8'($urandom);
            rst_n  = ($urandom_range(0, 299) != 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dk_hs_ram_arbiter.md
DK_HS_RAM_ARBITER -- requirements
Module: dk_hs_ram_arbiter

Shares the 8-bit work RAM port between the main CPU and the hiscore engine. The engine gets access only after the CPU is confirmed paused.

Parameters
REQ-001 The block SHALL have parameter AW, default 16, meaning RAM address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning RAM data width.
REQ-003 The block SHALL have parameter SETTLE, default 4, meaning the number of consecutive paused cycles required before grant (range 1..15).
REQ-004 The block SHALL have parameter HOLD, default 2, meaning the number of cycles pause is held after release (range 1..15).

Interface
REQ-005 The block SHALL have port I_CLK_24576M, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port I_RESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port I_CPU_A, input, AW bits: CPU RAM address.
REQ-008 The block SHALL have port I_CPU_D, input, DW bits: CPU write data.
REQ-009 The block SHALL have port I_CPU_WE, input, 1 bit: CPU write strobe.
REQ-010 The block SHALL have port I_CPU_PAUSED, input, 1 bit: the CPU reports it is halted.
REQ-011 The block SHALL have port I_HS_A, input, AW bits: hiscore address.
REQ-012 The block SHALL have port I_HS_D, input, DW bits: hiscore write data.
REQ-013 The block SHALL have port I_HS_WE, input, 1 bit: hiscore write strobe.
REQ-014 The block SHALL have port I_HS_REQ, input, 1 bit: hiscore access intent (read or write).
REQ-015 The block SHALL have port I_RAM_Q, input, DW bits: RAM read data.
REQ-016 The block SHALL have port O_RAM_A, output, AW bits: muxed RAM address.
REQ-017 The block SHALL have port O_RAM_D, output, DW bits: muxed RAM write data.
REQ-018 The block SHALL have port O_RAM_WE, output, 1 bit: muxed RAM write enable.
REQ-019 The block SHALL have port O_HS_Q, output, DW bits: read data to the hiscore engine.
REQ-020 The block SHALL have port O_PAUSE_REQ, output, 1 bit: request to pause the CPU.
REQ-021 The block SHALL have port O_HS_GRANT, output, 1 bit: the hiscore engine owns the RAM.
REQ-022 The block SHALL have port O_CONFLICT, output, 1 bit: sticky ownership-violation flag.

Function
REQ-023 The block SHALL implement exactly four states: IDLE, WAIT, OWN, REL.
REQ-024 In IDLE, the RAM mux SHALL select the CPU: O_RAM_A=I_CPU_A, O_RAM_D=I_CPU_D, O_RAM_WE=I_CPU_WE; O_PAUSE_REQ=0; O_HS_GRANT=0.
REQ-025 In IDLE, when I_HS_REQ=1, the state SHALL go to WAIT, and O_PAUSE_REQ SHALL be 1 from the next cycle.
REQ-026 In WAIT, the mux SHALL select the CPU and a settle counter SHALL increment each cycle I_CPU_PAUSED=1.
REQ-027 In WAIT, the settle counter SHALL clear to 0 in any cycle I_CPU_PAUSED=0.
REQ-028 In WAIT, when the counter reaches SETTLE, the state SHALL go to OWN.
REQ-029 In WAIT, if I_HS_REQ drops before grant, the state SHALL go directly to REL.
REQ-030 In OWN, O_HS_GRANT SHALL be 1 and the mux SHALL select the hiscore side: O_RAM_A=I_HS_A, O_RAM_D=I_HS_D, O_RAM_WE=I_HS_WE.
REQ-031 O_HS_GRANT SHALL be asserted in the first cycle of OWN, i.e. SETTLE+1 cycles after the first paused cycle.
REQ-032 O_HS_Q SHALL be I_RAM_Q registered, giving 1 cycle of block latency on top of RAM latency.
REQ-033 O_HS_Q SHALL update only in OWN and hold its value otherwise.
REQ-034 In OWN, when I_HS_REQ=0, the state SHALL go to REL.
REQ-035 In OWN, if I_CPU_PAUSED=0 in any cycle, O_RAM_WE SHALL be forced to 0 combinationally in that cycle.
REQ-036 On that same I_CPU_PAUSED=0 condition in OWN, O_CONFLICT SHALL set and the state SHALL go to REL.
REQ-037 In REL, the mux SHALL select the CPU, O_RAM_WE SHALL be forced to 0, O_HS_GRANT=0 and O_PAUSE_REQ=1.
REQ-038 REL SHALL last exactly HOLD cycles and then go to IDLE; O_PAUSE_REQ SHALL be 0 from the IDLE cycle.
REQ-039 I_HS_REQ rising during REL SHALL be ignored until IDLE; it SHALL then be sampled normally, with no lost or duplicated grant.
REQ-040 O_CONFLICT SHALL also set if I_CPU_WE=1 while in OWN.
REQ-041 O_CONFLICT SHALL clear only on reset.
REQ-042 The settle and hold counters SHALL be 4 bits, saturate rather than wrap, and clear on every state entry.
REQ-043 All outputs other than the RAM mux and O_RAM_WE SHALL be registered.

Reset
REQ-044 While I_RESETn=0, the block SHALL asynchronously be in state IDLE with both counters at 0.
REQ-045 While I_RESETn=0, O_PAUSE_REQ, O_HS_GRANT, O_CONFLICT and O_HS_Q SHALL all be 0, and O_RAM_WE SHALL be 0 regardless of I_CPU_WE.
REQ-046 Reset asserted mid-OWN SHALL drop the grant and the pause request in the same cycle, with no further hiscore write.
REQ-047 After I_RESETn releases, the first state change SHALL occur on the first clock edge at which I_RESETn=1.

Verification
REQ-048 Nominal path: I_HS_REQ=1, then I_CPU_PAUSED=1 two cycles later -> O_PAUSE_REQ=1 one cycle after the request; O_HS_GRANT=1 five cycles after paused rises; a hiscore write of 0x5A to address 0x6100 appears on the O_RAM_* port.
REQ-049 Paused glitch: paused=1 for 3 cycles, 0 for 1 cycle, then 1 -> the counter restarts and the grant arrives 5 cycles after the final rise.
REQ-050 Abandoned request: I_HS_REQ drops in WAIT -> REL for 2 cycles, then IDLE; no grant; O_RAM_WE follows I_CPU_WE again in IDLE.
REQ-051 Unpause in OWN: paused=0 while I_HS_WE=1 -> O_RAM_WE=0 in that cycle, O_CONFLICT=1 and stays set; state goes to REL.
REQ-052 Reset in OWN: I_RESETn=0 -> grant, pause request and O_RAM_WE are 0 immediately; after release, a fresh request completes normally.
REQ-053 Read latency: in OWN, address 0x6000 with RAM returning 0xC3 -> O_HS_Q=0xC3 one clock after I_RAM_Q is valid.
